mem_bist_m: RTL and testbench

- Synthesizable memory built-in self-test engine.
- Sits on the CPU memory port (address/data/WE/OE) beside the RAM. While it runs, it holds the CPU paused and owns the bus.
- Runs a full write sweep, then a read-back-and-compare sweep, over a parametrised window. The data pattern is selectable.
- Reports pass/fail, a saturating error count, and details of the first failure. This replaces bench-side forced bus sweeps with an on-chip self-test.

---
 rtl/mem_bist_pkg.sv | 34 +++
 rtl/mem_bist_rd_pipe_m.sv | 59 +++++
 rtl/mem_bist_m.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_bist_m.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and pattern generator for the memory BIST engine.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  localparam logic [1:0] MODE_DOWN    = 2'd0;
  localparam logic [1:0] MODE_ADDR    = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_SOLID   = 2'd3;

  // Data word for offset i; caller truncates to its own data width.
  function automatic logic [63:0] bist_pattern(input logic [31:0] i,
                                               input logic [1:0]  mode,
                                               input logic [63:0] seed,
                                               input int unsigned dw);
    logic [63:0] raw;
    logic [63:0] mask;
    mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    case (mode)
      MODE_DOWN:    raw = ~{32'd0, i};
      MODE_ADDR:    raw = {32'd0, i};
      MODE_CHECKER: raw = i[0] ? {32{2'b10}} : {32{2'b01}};
      default:      raw = seed;
    endcase
    return raw & mask;
  endfunction

endpackage

// File: rtl/mem_bist_rd_pipe_m.sv
// Delay line carrying {valid, address, expected data} alongside RAM read latency.
module mem_bist_rd_pipe_m
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_exp,
  output logic                  out_vld,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_exp
);

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]   addr_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   addr_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   exp_q  [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   exp_d  [READ_LATENCY];

  // Shift one stage per cycle; flush kills every in-flight valid bit.
  always_comb begin
    vld_d[0]  = in_vld & ~flush;
    addr_d[0] = in_addr;
    exp_d[0]  = in_exp;
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k]  = vld_q[k-1] & ~flush;
      addr_d[k] = addr_q[k-1];
      exp_d[k]  = exp_q[k-1];
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        addr_q[k] <= '0;
        exp_q[k]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < READ_LATENCY; k++) begin
        addr_q[k] <= addr_d[k];
        exp_q[k]  <= exp_d[k];
      end
    end
  end

  assign out_vld  = vld_q[READ_LATENCY-1];
  assign out_addr = addr_q[READ_LATENCY-1];
  assign out_exp  = exp_q[READ_LATENCY-1];

endmodule

// File: rtl/mem_bist_m.sv
// Memory BIST engine: write sweep, read-back compare sweep, result reporting.
module mem_bist_m
  import mem_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    DEPTH         = 32768,
  parameter int                    READ_LATENCY  = 1,
  parameter int                    ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [DATA_WIDTH-1:0]    seed,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_we,
  output logic                     mem_oe,
  output logic                     cpu_pause,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     aborted,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic [DATA_WIDTH-1:0]    first_err_exp,
  output logic [DATA_WIDTH-1:0]    first_err_act
);

  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
  // DRAIN waits READ_LATENCY cycles for the last read plus one so the final
  // compare has landed in err_count before pass is evaluated.
  localparam logic [2:0]        DRAIN_LAST = 3'(READ_LATENCY);

  bist_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [2:0]              drain_q, drain_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic [DATA_WIDTH-1:0]   pat;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_oe_q, mem_oe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    aborted_q, aborted_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
  logic [DATA_WIDTH-1:0]   first_err_exp_q, first_err_exp_d;
  logic [DATA_WIDTH-1:0]   first_err_act_q, first_err_act_d;

  logic                    start_ok, abort_ok;
  logic                    pipe_vld;
  logic [ADDR_WIDTH-1:0]   pipe_addr;
  logic [DATA_WIDTH-1:0]   pipe_exp;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign abort_ok = abort && busy_q;

  mem_bist_rd_pipe_m #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (abort_ok),
    .in_vld  (mem_oe_q),
    .in_addr (mem_addr_q),
    .in_exp  (exp_q),
    .out_vld (pipe_vld),
    .out_addr(pipe_addr),
    .out_exp (pipe_exp)
  );

  // Next-state, compare/accumulate and registered-output computation.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    drain_d          = drain_q;
    mode_d           = mode_q;
    seed_d           = seed_q;
    done_d           = done_q;
    pass_d           = pass_q;
    aborted_d        = aborted_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    first_err_exp_d  = first_err_exp_q;
    first_err_act_d  = first_err_act_q;
    mem_addr_d       = mem_addr_q;

    // A zero count means no mismatch has been seen yet (saturation never wraps).
    if (pipe_vld && !abort_ok && (mem_rdata != pipe_exp)) begin
      if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
      if (err_count_q == '0) begin
        first_err_addr_d = pipe_addr;
        first_err_exp_d  = pipe_exp;
        first_err_act_d  = mem_rdata;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d          = WRITE;
          idx_d            = '0;
          mode_d           = mode;
          seed_d           = seed;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          aborted_d        = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          first_err_exp_d  = '0;
          first_err_act_d  = '0;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = READ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      READ: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else drain_d = drain_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase

    if (abort_ok) begin
      state_d   = DONE;
      aborted_d = 1'b1;
    end

    if ((state_d == DONE) && (state_q != DONE)) begin
      done_d = 1'b1;
      pass_d = !aborted_d && (err_count_d == '0);
    end

    busy_d      = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    mem_we_d    = (state_d == WRITE);
    mem_oe_d    = (state_d == READ);
    pat         = DATA_WIDTH'(bist_pattern(32'(idx_d), mode_d, 64'(seed_d), DATA_WIDTH));
    mem_wdata_d = mem_we_d ? pat : '0;
    exp_d       = pat;
    if (mem_we_d || mem_oe_d) mem_addr_d = BASE_ADDR + ADDR_WIDTH'(idx_d);
  end

  // All state and registered outputs; async reset returns everything to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      drain_q          <= '0;
      mode_q           <= '0;
      seed_q           <= '0;
      exp_q            <= '0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_we_q         <= 1'b0;
      mem_oe_q         <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      aborted_q        <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      first_err_exp_q  <= '0;
      first_err_act_q  <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      drain_q          <= drain_d;
      mode_q           <= mode_d;
      seed_q           <= seed_d;
      exp_q            <= exp_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_we_q         <= mem_we_d;
      mem_oe_q         <= mem_oe_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      aborted_q        <= aborted_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_exp_q  <= first_err_exp_d;
      first_err_act_q  <= first_err_act_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_we         = mem_we_q;
  assign mem_oe         = mem_oe_q;
  assign busy           = busy_q;
  assign cpu_pause      = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign aborted        = aborted_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_exp  = first_err_exp_q;
  assign first_err_act  = first_err_act_q;

endmodule

// File: tb/tb_mem_bist_m.sv
// Bench for mem_bist_m: RAM model with fault injection, write scoreboard, result queue.
module tb_mem_bist_m;

  localparam int D = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: DEPTH 16, latency 1, 16-bit error counter.
  logic        start_a, abort_a;
  logic [1:0]  mode_a;
  logic [7:0]  seed_a, rdata_a, wdata_a, fe_a, fx_a;
  logic [15:0] addr_a, err_a, fa_a;
  logic        we_a, oe_a, pause_a, busy_a, done_a, pass_a, ab_a;

  mem_bist_m #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .BASE_ADDR(16'h0000), .DEPTH(D),
               .READ_LATENCY(1), .ERR_CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .mode(mode_a),
    .seed(seed_a), .mem_rdata(rdata_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_we(we_a), .mem_oe(oe_a), .cpu_pause(pause_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .aborted(ab_a), .err_count(err_a), .first_err_addr(fa_a),
    .first_err_exp(fe_a), .first_err_act(fx_a));

  // Instance B: latency 3, 3-bit saturating counter, RAM always reads 0.
  logic        start_b, abort_b;
  logic [1:0]  mode_b;
  logic [7:0]  seed_b, wdata_b, fe_b, fx_b;
  logic [7:0]  rdata_b = 8'h00;
  logic [15:0] addr_b, fa_b;
  logic [2:0]  err_b;
  logic        we_b, oe_b, pause_b, busy_b, done_b, pass_b, ab_b;

  mem_bist_m #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .BASE_ADDR(16'h0000), .DEPTH(D),
               .READ_LATENCY(3), .ERR_CNT_WIDTH(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .mode(mode_b),
    .seed(seed_b), .mem_rdata(rdata_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_we(we_b), .mem_oe(oe_b), .cpu_pause(pause_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .aborted(ab_b), .err_count(err_b), .first_err_addr(fa_b),
    .first_err_exp(fe_b), .first_err_act(fx_b));

  // RAM model for instance A with injectable read faults.
  logic [7:0] ram [0:15];
  bit         fault_en = 0, zero_rd = 0;
  logic [3:0] fault_addr = 4'd0;

  function automatic logic [7:0] ram_rd(input logic [3:0] a);
    logic [7:0] v;
    v = ram[a];
    if (zero_rd) v = 8'h00;
    else if (fault_en && (a == fault_addr)) v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (we_a) ram[addr_a[3:0]] <= wdata_a;
    if (oe_a) rdata_a <= ram_rd(addr_a[3:0]);
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input logic [1:0] m, input logic [7:0] s);
    case (m)
      2'd0:    return 8'(255 - i);
      2'd1:    return 8'(i);
      2'd2:    return (i % 2 == 1) ? 8'hAA : 8'h55;
      default: return s;
    endcase
  endfunction

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t wr_q[$];

  typedef struct {
    int          cyc;
    logic        pass;
    logic [15:0] errs;
    logic [15:0] fa;
    logic [7:0]  fe;
    logic [7:0]  fx;
  } res_t;
  res_t res_q[$];

  // Write scoreboard: every write beat on instance A must match the next expected word.
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (we_a) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", addr_a, e.a);
        chk("wr_data", wdata_a, e.d);
      end
      chk("we_oe_excl", oe_a, 0);
    end
  end

  task automatic push_writes(input logic [1:0] m, input logic [7:0] s, input int cnt);
    for (int i = 0; i < cnt; i++) wr_q.push_back('{a: 16'(i), d: pat(i, m, s)});
  endtask

  // Full run on instance A; restart_at > 0 injects an extra start pulse mid-run.
  task automatic run_a(input logic [1:0] m, input logic [7:0] s, input res_t r,
                       input int restart_at);
    int   n;
    bit   got;
    res_t e;
    push_writes(m, s, D);
    res_q.push_back(r);
    @(negedge clk);
    mode_a = m; seed_a = s; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("run_busy_after_start", {busy_a, pause_a, done_a}, 3'b110);
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      start_a = (restart_at > 0) && (n == restart_at);
      got = done_a;
    end
    start_a = 1'b0;
    chk("run_done_seen", got, 1);
    e = res_q.pop_front();
    chk("run_done_cycle", n, e.cyc);
    chk("run_pass", pass_a, e.pass);
    chk("run_aborted", ab_a, 0);
    chk("run_err_count", err_a, e.errs);
    chk("run_first_err", {fa_a, fe_a, fx_a}, {e.fa, e.fe, e.fx});
    chk("run_bus_idle", {busy_a, pause_a, we_a, oe_a, wdata_a}, '0);
    chk("run_writes_drained", wr_q.size(), 0);
  endtask

  initial begin
    int n;
    bit got;
    reset = 1'b1;
    start_a = 0; abort_a = 0; mode_a = 0; seed_a = 0;
    start_b = 0; abort_b = 0; mode_b = 0; seed_b = 0;
    #1;
    chk("reset_ctl", {addr_a, wdata_a, we_a, oe_a, pause_a, busy_a, done_a, pass_a, ab_a}, '0);
    chk("reset_res", {err_a, fa_a, fe_a, fx_a}, '0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Mode 0 fault-free with an ignored second start at edge 10.
    run_a(2'd0, 8'h00, '{cyc: 34, pass: 1, errs: 0, fa: 0, fe: 0, fx: 0}, 9);
    chk("ram5_after_mode0", ram[5], 8'hFA);

    // Checkerboard, bit0 stuck-at-0 at odd address 3: 0xAA is unaffected.
    fault_en = 1; fault_addr = 4'd3;
    run_a(2'd2, 8'h00, '{cyc: 34, pass: 1, errs: 0, fa: 0, fe: 0, fx: 0}, 0);
    // Same fault at address 2: 0x55 reads back as 0x54.
    fault_addr = 4'd2;
    run_a(2'd2, 8'h00, '{cyc: 34, pass: 0, errs: 1, fa: 16'd2, fe: 8'h55, fx: 8'h54}, 0);
    fault_en = 0;

    // Solid seed, every read wrong.
    zero_rd = 1;
    run_a(2'd3, 8'h3C, '{cyc: 34, pass: 0, errs: 16, fa: 16'd0, fe: 8'h3C, fx: 8'h00}, 0);
    zero_rd = 0;

    // Instance B: latency 3 timing and counter saturation.
    @(negedge clk);
    mode_b = 2'd3; seed_b = 8'h3C; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      got = done_b;
    end
    chk("b_done_seen", got, 1);
    chk("b_done_cycle", n, 36);
    chk("b_err_sat", err_b, 3'd7);
    chk("b_pass", {pass_b, ab_b}, 2'b00);
    chk("b_first_err", {fa_b, fe_b, fx_b}, {16'd0, 8'h3C, 8'h00});

    // Start and abort together from DONE: start wins; then abort at write offset 5.
    push_writes(2'd1, 8'h00, 6);
    @(negedge clk);
    mode_a = 2'd1; start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0;
    chk("start_over_abort", {busy_a, done_a, we_a}, 3'b101);
    n = 0;
    while (n < 40 && !(we_a && addr_a == 16'd5)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reached_off5", we_a && (addr_a == 16'd5), 1);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("abort_result", {done_a, ab_a, pass_a, we_a, oe_a, pause_a, busy_a}, 7'b1100000);
    chk("abort_err_kept", err_a, 0);
    chk("abort_writes", wr_q.size(), 0);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("abort_in_done_ignored", {done_a, ab_a, busy_a}, 3'b110);

    // Async reset in the middle of READ.
    push_writes(2'd1, 8'h00, D);
    @(negedge clk);
    mode_a = 2'd1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (n < 60 && !(oe_a && addr_a == 16'd4)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_read4", oe_a && (addr_a == 16'd4), 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ctl", {addr_a, wdata_a, we_a, oe_a, pause_a, busy_a, done_a, pass_a, ab_a}, '0);
    chk("midrst_res", {err_a, fa_a, fe_a, fx_a}, '0);
    @(negedge clk); reset = 1'b0;
    run_a(2'd1, 8'h00, '{cyc: 34, pass: 1, errs: 0, fa: 0, fe: 0, fx: 0}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
